// File: rtl/ramstr_pkg.sv
// Shared types and constants for the RAM string streamer.
package ramstr_pkg;

  localparam int unsigned RAMSTR_ADDR_W = 10;
  localparam int unsigned RAMSTR_DATA_W = 10;
  localparam logic [9:0]  NUL_WORD      = 10'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_string_streamer.sv
// Walks a NUL-terminated string in program RAM and streams its characters over valid/ready.
// Optional length guard: define RAMSTR_LEN_GUARD_EN to stop after MAX_LEN characters with err set.
module ram_string_streamer
  import ramstr_pkg::*;
#(
  parameter int unsigned ADDR_W  = RAMSTR_ADDR_W,
  parameter int unsigned DATA_W  = RAMSTR_DATA_W,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] ptr_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] len,
  output logic              err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   len_inc;
  logic                word_is_nul;
  logic                len_limit_hit;

  assign word_is_nul = (mem_rdata == DATA_W'(NUL_WORD));
  assign len_inc     = len_q + 1'b1;

`ifdef RAMSTR_LEN_GUARD_EN
  assign len_limit_hit = (len_inc == ADDR_W'(MAX_LEN));
`else
  assign len_limit_hit = 1'b0;
  // MAX_LEN only takes effect when the length guard is built in.
  if (MAX_LEN == 0) begin : g_max_len_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = indirect ? ST_PTR : ST_FETCH;
      ST_PTR:   state_d = ST_FETCH;
      ST_FETCH: state_d = word_is_nul ? ST_DONE : ST_EMIT;
      ST_EMIT:  if (char_ready) state_d = len_limit_hit ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    char_valid = (state_q == ST_EMIT);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    len_d  = len_q;
    err_d  = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = ptr_addr;
          len_d  = '0;
          err_d  = 1'b0;
        end
      end
      ST_PTR:   addr_d = ADDR_W'(mem_rdata);
      ST_FETCH: if (!word_is_nul) data_d = mem_rdata[7:0];
      ST_EMIT: begin
        if (char_ready) begin
          addr_d = addr_q + 1'b1;
          len_d  = len_inc;
          if (len_limit_hit) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      len_q  <= len_d;
      err_q  <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign char_data = data_q;
  assign len       = len_q;
  assign err       = err_q;

endmodule

// File: doc/ram_string_streamer.md
# ram_string_streamer

Walks a NUL-terminated character string held in the 10-bit, 1024-word program RAM and streams its characters one at a time over a valid/ready interface, e.g. toward a UART or display writer. Sits directly on the RAM's read side: it drives the RAM address and consumes the asynchronously read data word. Supports direct addressing, where the string base is given, and indirect addressing, where a pointer word in RAM is fetched first.

## Interface
- `ADDR_W`, 10, RAM address width.
- `DATA_W`, 10, RAM word width.
- `MAX_LEN`, 256, character limit used only when the length guard is compiled in.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a walk; sampled only in IDLE.
- `indirect`  in  1  sampled with `start`; 1 = `ptr_addr` holds the address of a pointer word, 0 = `ptr_addr` is the string base.
- `ptr_addr`  in  ADDR_W  pointer-slot or base address; sampled with `start`.
- `mem_addr`  out  ADDR_W  registered RAM address.
- `mem_rdata`  in  DATA_W  RAM read data; combinational function of `mem_addr`.
- `char_valid`  out  1  `char_data` is valid.
- `char_ready`  in  1  downstream accepts the character.
- `char_data`  out  8  low 8 bits of the RAM word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a walk.
- `len`  out  ADDR_W  characters emitted in the last or current walk.
- `err`  out  1  walk stopped by the length guard; valid with `done`.

## Operation
- States:
  - IDLE: `start` → PTR if `indirect`, else FETCH. On the same edge, `mem_addr` is loaded with `ptr_addr` and `len` is cleared to 0.
  - PTR: `mem_addr` is loaded with `mem_rdata`; next state is FETCH.
  - FETCH: if `mem_rdata` (all 10 bits) equals 0 → DONE. Otherwise `char_data` is loaded with `mem_rdata[7:0]` and the next state is EMIT.
  - EMIT: `char_valid` is 1. When `char_valid && char_ready`: `mem_addr` increments, `len` increments, next state is FETCH.
  - DONE: `done` is 1 for one cycle; next state is IDLE.
- The NUL test uses the full word. Bits 9:8 of a non-zero word are dropped from `char_data`.
- Address arithmetic is modulo 2^ADDR_W, so 1023 + 1 wraps to 0 and the walk continues.
- The pointer fetched in PTR is used as a full 10-bit address with no range check.
- `start` while `busy` is ignored. `start` together with reset: reset wins.
- `char_data` and `char_valid` hold stable while `char_ready` is low.
- `len` holds its final value through IDLE until the next `start`.
- Reset mid-walk abandons the walk; no `done` pulse is produced.

## Timing
- Reset values: state IDLE, `mem_addr` 0, `char_valid` 0, `char_data` 0, `busy` 0, `done` 0, `len` 0, `err` 0.
- Direct mode: the first `char_valid` is asserted 2 cycles after the `start` edge. Indirect mode adds 1 cycle.
- Steady state is 2 cycles per character with `char_ready` tied high.
- Empty string: `done` pulses 2 cycles after `start` in direct mode, 3 in indirect mode.
- `busy` rises on the cycle after the `start` edge and falls on the edge that leaves DONE.

## Configuration
- `RAMSTR_LEN_GUARD_EN` defined:
  - In EMIT, if the accepted character makes `len` equal to `MAX_LEN`, the next state is DONE instead of FETCH.
  - `err` is set to 1 and held until the next `start`.
- `RAMSTR_LEN_GUARD_EN` undefined:
  - The walk is unbounded and ends only at a NUL word.
  - `err` is tied to 0 and `MAX_LEN` is unused.

## Structure
- Package `ramstr_pkg` holds:
  - the state enum (IDLE, PTR, FETCH, EMIT, DONE);
  - the `ADDR_W` and `DATA_W` defaults;
  - the `NUL_WORD` constant, 10'd0.
- Single module with no sub-modules. The FSM, address counter and length counter are small enough to keep inline.

## Test plan
- Bench RAM: addresses 3..20 hold "WafflesAndPancakes", ram[21] = 0, ram[0] = 3. `start` with `indirect=1`, `ptr_addr=0`, `char_ready` high → 18 characters 'W'..'s' in order, `done` pulse, `len` = 18, `err` = 0.
- `start` with `indirect=0`, `ptr_addr=21` → no `char_valid`, `done` 2 cycles after `start`, `len` = 0.
- Walk from base 3 with `char_ready` held low for 5 cycles at the 'f' character → `char_data` = 0x66 stable for all 5 cycles, no character skipped, `len` = 18.
- ram[1023] = 'X', ram[0] = 'Y', ram[1] = 0, direct base 1023 → 'X' then 'Y', `mem_addr` wraps from 1023 to 0, `len` = 2.
- Deassert `rst_n` after 4 characters of the first walk → all outputs at reset values immediately, no `done`. A following `start` replays the string from 'W'.
- Build with `RAMSTR_LEN_GUARD_EN` and `MAX_LEN` = 4, walk from base 3 → 'W','a','f','f', then `done` with `err` = 1 and `len` = 4.
